// File: rtl/oam_dma_if.sv
// CPU-side register bus, DMA source read bus and OAM write port of the OAM DMA engine.
// Latency: none; plain wires grouping the signals.
// Backpressure: none; strobes are single-cycle and always accepted.
interface oam_dma_if;
  logic [15:0] address;
  logic [7:0]  indata;
  logic [7:0]  outdata;
  logic        load;
  logic        store;
  logic        cpu_block;
  logic [15:0] bus_address;
  logic        bus_load;
  logic [7:0]  bus_rdata;
  logic [7:0]  oam_address;
  logic [7:0]  oam_wdata;
  logic        oam_store;
  logic        dma_active;

  // DMA engine view
  modport slave (
    input  address, indata, load, store, bus_rdata,
    output outdata, cpu_block, bus_address, bus_load,
           oam_address, oam_wdata, oam_store, dma_active
  );

  // CPU / memory side view
  modport master (
    output address, indata, load, store, bus_rdata,
    input  outdata, cpu_block, bus_address, bus_load,
           oam_address, oam_wdata, oam_store, dma_active
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA: copies LENGTH bytes from {src_hi,8'h00} into OAM after a write to REG_ADDR.
// Latency: 1 START cycle, then one read per cycle; each OAM write lags its read by READ_LATENCY.
// Backpressure: none; the source bus is assumed always ready, a new write restarts the transfer.
module oam_dma #(
  parameter logic [15:0] REG_ADDR     = 16'hff46,
  parameter int          LENGTH       = 160,
  parameter int          READ_LATENCY = 2
) (
  input  logic      clockgb,
  input  logic      resetn,
  oam_dma_if.slave  io
);

  typedef enum logic [1:0] {IDLE, START, XFER, DRAIN} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  src_reg;
  logic [7:0]  src_hi;
  logic [8:0]  issue_cnt;
  logic        issue_vld;
  logic        reg_hit;
  logic        reg_wr;
  logic        final_store;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [7:0]  idx_pipe [READ_LATENCY];

  // Register decode, readback, echo-region folding and CPU blocking window
  always_comb begin
    reg_hit        = (io.address == REG_ADDR);
    reg_wr         = io.store && reg_hit;
    io.outdata     = (io.load && reg_hit) ? src_reg : 8'h00;
    src_hi         = (src_reg >= 8'he0) ? (src_reg & 8'hdf) : src_reg;
    io.dma_active  = (state != IDLE);
    io.cpu_block   = io.dma_active && !reg_hit &&
                     !((io.address >= 16'hff80) && (io.address <= 16'hfffe));
    io.oam_store   = vld_pipe[READ_LATENCY-1];
    io.oam_address = io.oam_store ? idx_pipe[READ_LATENCY-1] : 8'h00;
    io.oam_wdata   = io.oam_store ? io.bus_rdata : 8'h00;
    final_store    = io.oam_store && (idx_pipe[READ_LATENCY-1] == 8'(LENGTH - 1));
  end

  // Next-state and read-issue logic; a register write always restarts from START
  always_comb begin
    state_nxt      = state;
    issue_vld      = 1'b0;
    io.bus_load    = 1'b0;
    io.bus_address = 16'h0000;
    case (state)
      IDLE:  ;
      START: state_nxt = XFER;
      XFER: begin
        issue_vld      = 1'b1;
        io.bus_load    = 1'b1;
        // low byte never carries since issue_cnt stays below 256
        io.bus_address = {src_hi, issue_cnt[7:0]};
        if (issue_cnt == 9'(LENGTH - 1)) state_nxt = DRAIN;
      end
      DRAIN: if (final_store) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reg_wr) state_nxt = START;
  end

  // State register
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Source register and issue counter
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      src_reg   <= 8'hff;
      issue_cnt <= 9'd0;
    end else if (reg_wr) begin
      src_reg   <= io.indata;
      issue_cnt <= 9'd0;
    end else if (issue_vld) begin
      issue_cnt <= issue_cnt + 9'd1;
    end
  end

  // Read-latency shift pipeline; a restart flushes reads still in flight
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) idx_pipe[i] <= 8'h00;
    end else if (reg_wr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue_vld;
      idx_pipe[0] <= issue_cnt[7:0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter REG_ADDR, default 16'hff46, CPU address of the DMA source/start register.
REQ-002 Parameter LENGTH, default 160, number of bytes copied per transfer (1..256).
REQ-003 Parameter READ_LATENCY, default 2, cycles from bus_load to valid bus_rdata (1..4).
REQ-004 clockgb  input  1  system clock; all state changes on its rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 address  input  16  CPU bus address.
REQ-007 indata  input  8  CPU write data.
REQ-008 outdata  output  8  CPU read data; 8'h00 when REG_ADDR not addressed.
REQ-009 load  input  1  CPU read strobe.
REQ-010 store  input  1  CPU write strobe.
REQ-011 bus_address  output  16  DMA source read address.
REQ-012 bus_load  output  1  DMA source read strobe, one byte per asserted cycle.
REQ-013 bus_rdata  input  8  source data, valid exactly READ_LATENCY cycles after bus_load.
REQ-014 oam_address  output  8  OAM write index.
REQ-015 oam_wdata  output  8  OAM write data.
REQ-016 oam_store  output  1  OAM write strobe.
REQ-017 dma_active  output  1  high from start acceptance until the last OAM write completes.
REQ-018 cpu_block  output  1  combinational: dma_active AND address outside 16'hff80..16'hfffe AND address != REG_ADDR.

Function
REQ-019 Register write: store && address==REG_ADDR latches indata into src_reg and starts a transfer.
REQ-020 Register read: load && address==REG_ADDR drives outdata = src_reg in the same cycle (combinational).
REQ-021 Source base = {src_hi, 8'h00}; src_hi = src_reg, except src_reg >= 8'he0 uses src_reg with bit 5 cleared (echo to 8'hc0..8'hdf).
REQ-022 States: IDLE, START, XFER, DRAIN; IDLE on reset.
REQ-023 IDLE -> START on register write; START lasts exactly 1 cycle, dma_active already high, no bus_load.
REQ-024 START -> XFER; XFER asserts bus_load every cycle with bus_address = base + issue_cnt, issue_cnt 0..LENGTH-1.
REQ-025 After issuing issue_cnt == LENGTH-1, XFER -> DRAIN; bus_load low in DRAIN.
REQ-026 READ_LATENCY-deep valid/index shift pipeline: each bus_load produces oam_store exactly READ_LATENCY cycles later, oam_address = its issue index, oam_wdata = bus_rdata.
REQ-027 DRAIN -> IDLE the cycle after the final oam_store (index LENGTH-1); dma_active falls in that same transition.
REQ-028 Total dma_active duration = 1 + LENGTH + READ_LATENCY cycles (163 with defaults).
REQ-029 issue_cnt is 9 bits; base + issue_cnt never carries out of the low byte for LENGTH <= 256.
REQ-030 Register write during START/XFER/DRAIN: src_reg updated, in-flight pipeline entries cleared (no oam_store from old transfer), state -> START, counters to 0.
REQ-031 Register write in same cycle as final oam_store: the final store still occurs; next state START, not IDLE.
REQ-032 oam_store, bus_load never asserted in IDLE or START.
REQ-033 CPU accesses while cpu_block high are the bus owner's responsibility to suppress; this block does not gate load/store except via cpu_block.

Reset
REQ-034 On resetn low: state IDLE, src_reg 8'hff, counters 0, pipeline valid bits 0, dma_active 0, bus_load 0, oam_store 0, bus_address 16'h0000, oam_address 8'h00, oam_wdata 8'h00.
REQ-035 Reset mid-transfer aborts immediately; no further bus_load or oam_store after resetn falls.

Verification
REQ-036 Write 8'hc1 to ff46 -> 1 idle cycle, bus_address c100..c19f on 160 consecutive cycles, oam_store index 0..159 with data from c100.. lagging 2 cycles, dma_active high 163 cycles.
REQ-037 Write 8'hfe -> reads from de00..de9f.
REQ-038 Second write 8'h80 at XFER cycle 50 -> no store from old transfer after that cycle, restart at 8000 index 0, full 160 stores.
REQ-039 During transfer: address ff90 -> cpu_block 0; address c000 -> cpu_block 1; read ff46 -> outdata last written value.
REQ-040 resetn low at XFER cycle 20 -> all outputs at reset values, outdata on ff46 read = 8'hff.
REQ-041 Write ff46 in final-store cycle -> index 159 written, then 1-cycle START, new transfer runs to completion.
